// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the register file's two write ports among NREQ completing functional
// units. Each cycle the requesters are scanned in rotating order starting at
// rr_ptr. The first valid requester with a non-zero destination takes port 0
// (slot A). The next one whose destination differs from slot A's takes port 1
// (slot B). Writes to x0 are acknowledged without using a port. Accepted
// writes are registered and appear on the write ports one cycle later.
//
// Optional feature macro: WB_ARB_STATS_EN adds the conflict_cnt port and a
// saturating counter of cycles in which a real write request had to wait.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    per-requester writeback valid
//   req_ready    per-requester accept (combinational)
//   req_rd       per-requester destination register, 5 bits each
//   req_data     per-requester result, XLEN bits each
//   we0/wr_addr0/wr_din0   registered write port 0 (slot A)
//   we1/wr_addr1/wr_din1   registered write port 1 (slot B)
//   conflict_cnt saturating wait-cycle counter (WB_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*5-1:0]    req_rd,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic                 we0,
   output logic [4:0]           wr_addr0,
   output logic [XLEN-1:0]      wr_din0,
   output logic                 we1,
   output logic [4:0]           wr_addr1,
   output logic [XLEN-1:0]      wr_din1
`ifdef WB_ARB_STATS_EN
   ,
   output logic [15:0]          conflict_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr_r;
   logic [PW-1:0]   rr_next_s;
   logic [PW-1:0]   last_idx_s;
   logic            found_a_s;
   logic            found_b_s;
   logic [PW-1:0]   a_idx_s;
   logic [PW-1:0]   b_idx_s;
   logic [4:0]      a_rd_s;
   logic [4:0]      b_rd_s;
   logic [XLEN-1:0] a_data_s;
   logic [XLEN-1:0] b_data_s;

   // Rotating scan: pick slot A, slot B and acknowledge x0 writes
   always_comb begin : scan
      int         idx_v;
      logic [4:0] rd_v;
      req_ready = '0;
      found_a_s = 1'b0;
      found_b_s = 1'b0;
      a_idx_s   = '0;
      b_idx_s   = '0;
      a_rd_s    = 5'd0;
      b_rd_s    = 5'd0;
      a_data_s  = '0;
      b_data_s  = '0;
      idx_v     = 0;
      rd_v      = 5'd0;
      for (int k = 0; k < NREQ; k++) begin
         idx_v = (int'(rr_ptr_r) + k) % NREQ;
         rd_v  = req_rd[idx_v*5 +: 5];
         if (req_valid[idx_v]) begin
            if (rd_v == 5'd0) begin
               // x0 is never written, so the request is simply absorbed
               req_ready[idx_v] = 1'b1;
            end else if (!found_a_s) begin
               found_a_s        = 1'b1;
               a_idx_s          = PW'(idx_v);
               a_rd_s           = rd_v;
               a_data_s         = req_data[idx_v*XLEN +: XLEN];
               req_ready[idx_v] = 1'b1;
            end else if (!found_b_s && (rd_v != a_rd_s)) begin
               // Same-rd as slot A is refused so both ports never alias
               found_b_s        = 1'b1;
               b_idx_s          = PW'(idx_v);
               b_rd_s           = rd_v;
               b_data_s         = req_data[idx_v*XLEN +: XLEN];
               req_ready[idx_v] = 1'b1;
            end else begin
               req_ready[idx_v] = 1'b0;
            end
         end else begin
            req_ready[idx_v] = 1'b0;
         end
      end
   end

   // Next priority pointer: one past the last real grant
   always_comb begin
      last_idx_s = found_b_s ? b_idx_s : a_idx_s;
      if (last_idx_s == PW'(NREQ - 1)) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = last_idx_s + 1'b1;
      end
   end

   // Priority pointer register; x0-only cycles leave it unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= '0;
      end else if (found_a_s) begin
         rr_ptr_r <= rr_next_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Write port registers; address/data hold when the slot is empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we0      <= 1'b0;
         wr_addr0 <= 5'd0;
         wr_din0  <= '0;
         we1      <= 1'b0;
         wr_addr1 <= 5'd0;
         wr_din1  <= '0;
      end else begin
         we0 <= found_a_s;
         we1 <= found_b_s;
         if (found_a_s) begin
            wr_addr0 <= a_rd_s;
            wr_din0  <= a_data_s;
         end else begin
            wr_addr0 <= wr_addr0;
            wr_din0  <= wr_din0;
         end
         if (found_b_s) begin
            wr_addr1 <= b_rd_s;
            wr_din1  <= b_data_s;
         end else begin
            wr_addr1 <= wr_addr1;
            wr_din1  <= wr_din1;
         end
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [NREQ-1:0] live_s;
   logic            miss_s;

   // Requesters that need a real write port this cycle
   always_comb begin
      live_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         live_s[i] = req_valid[i] & (req_rd[i*5 +: 5] != 5'd0);
      end
   end

   assign miss_s = |(live_s & ~req_ready);

   // Saturating count of cycles where a real write had to wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= 16'd0;
      end else if (miss_s && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end else begin
         conflict_cnt <= conflict_cnt;
      end
   end
`endif

endmodule
